tt03_temperature_sensor: RTL and testbench
==========================================

Name: tt03_temperature_sensor

Overview:
Digital temperature-sensor tile with a Tiny-Tapeout-style packed 8-bit I/O. It repeatedly charges a sensor node, times its discharge in clock cycles, and latches the count as the reading. The reading is shown one decimal digit at a time on a 7-segment display. The raw sensor node state is also output as a PWM signal. In this build the sensor node is a synthesizable digital emulator, so discharge time depends only on the configuration input.

Parameters:
- CNT_W, 8, width of the discharge counter; saturates at 2^CNT_W-1.
- CHARGE_SLOW, 4, charge-phase length in cycles when io_in[2]=0.
- DIGIT_HOLD, 8, cycles each display phase (tens, ones, blank) is held.

Ports:
- io_in[0]  input  1  clk; single clock, all state on rising edge.
- io_in[1]  input  1  rst_n; asynchronous, active-low reset.
- io_in[2]  input  1  en_quick_trans; 1 = 1-cycle charge phase, 0 = CHARGE_SLOW cycles.
- io_in[7:3]  input  5  tempsens_cfg; sensor configuration value (emulated DAC code).
- io_out[6:0]  output  7  7-segment pattern, active-high, bit0=a … bit6=g.
- io_out[7]  output  1  tempsens_pwm; sensor node state, 1 = charged/discharging.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to CHARGE with the charge counter cleared.
  - Discharge counter = 0, latched reading = 0.
  - Display phase = BLANK and the display timer is cleared.
  - io_out = 8'h00 while reset is asserted.
- Measurement FSM states: CHARGE → DISCHARGE → LATCH → CHARGE, free-running.
- CHARGE:
  - pwm=1.
  - Lasts 1 cycle if en_quick_trans=1, otherwise CHARGE_SLOW cycles.
  - en_quick_trans is sampled on CHARGE entry.
- DISCHARGE:
  - pwm=1.
  - Sensor emulator holds the node high for D = 4*(tempsens_cfg+1) cycles.
  - tempsens_cfg is sampled on DISCHARGE entry; mid-measurement changes apply to the next measurement.
  - The counter increments every DISCHARGE cycle and saturates at 2^CNT_W-1.
  - Exit when the node falls, so count = D (max 128 for cfg=31).
- LATCH:
  - pwm=0, lasts 1 cycle.
  - reading ← min(count, 99); count ← 0.
- PWM period = charge_len + D + 1 cycles, with exactly 1 low cycle per period.
- Display sequencer (independent of the FSM):
  - Cycles through TENS → ONES → BLANK, each held DIGIT_HOLD cycles, starting in BLANK after reset.
  - The digit pair is snapshotted from the reading at each entry to TENS, so a display cycle never mixes two readings.
  - TENS shows reading/10, but is blank (7'h00) when the tens digit is 0.
  - ONES shows reading%10; BLANK shows 7'h00.
- Segment encodings (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- Outputs are registered (one cycle after internal state).
- Reset asserted mid-measurement aborts it; the reading returns to 0 and the display shows a single 0 digit until the first LATCH.

Test Plan:
- Reset: hold rst_n=0 → io_out=8'h00 regardless of the clock. Release → pwm rises on the first output cycle, display stays blank for DIGIT_HOLD cycles.
- Slow charge, cfg=3, quick=0 → pwm high 20 cycles, low 1 cycle, period 21. First reading 16: TENS shows 06, ONES shows 7D.
- Quick charge, cfg=3, quick=1 → pwm high 17, low 1. Reading remains 16.
- cfg=0, quick=1 → D=4, reading 4. TENS blank (00), ONES shows 66.
- cfg=31 → D=128, reading saturates to 99. Display shows 6F then 6F.
- Change cfg from 3 to 0 during DISCHARGE → current reading 16, next reading 4. Pulse rst_n low mid-DISCHARGE → io_out goes to 00 immediately and measurement restarts in CHARGE.

Source files
------------

// File: rtl/tt03_temperature_sensor.sv
// Temperature-sensor tile: times the discharge of an emulated sensor node and
// shows the latched reading as decimal digits on a 7-segment display.
module tt03_temperature_sensor #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CHARGE_SLOW = 4,
    parameter int unsigned DIGIT_HOLD  = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned CHW = (CHARGE_SLOW > 1) ? $clog2(CHARGE_SLOW) : 1;
    localparam int unsigned TW  = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;

    localparam logic [1:0] ST_CHARGE = 2'd0;
    localparam logic [1:0] ST_DISCH  = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;

    localparam logic [1:0] PH_BLANK = 2'd0;
    localparam logic [1:0] PH_TENS  = 2'd1;
    localparam logic [1:0] PH_ONES  = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       quick;
    logic [4:0] cfg;
    logic [7:0] dlen;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign quick = io_in[2];
    assign cfg   = io_in[7:3];
    // Emulated node hold time: 4*(cfg+1), at most 128.
    assign dlen  = {1'b0, cfg, 2'b00} + 8'd4;

    logic [1:0]       state_q, state_d;
    logic [CHW-1:0]   chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ntmr_q, ntmr_d;
    logic [6:0]       reading_q, reading_d;
    logic [1:0]       phase_q, phase_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [6:0]       seg_q, seg_d;
    logic             pwm_q, pwm_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        chg_d     = chg_q;
        cnt_d     = cnt_q;
        ntmr_d    = ntmr_q;
        reading_d = reading_q;
        case (state_q)
            ST_CHARGE: begin
                // Charge length is decided in the first CHARGE cycle.
                if ((chg_q == '0 && quick) || chg_q == CHW'(CHARGE_SLOW - 1)) begin
                    state_d = ST_DISCH;
                    chg_d   = '0;
                    ntmr_d  = dlen;
                end else begin
                    chg_d = chg_q + 1'b1;
                end
            end
            ST_DISCH: begin
                cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                ntmr_d = ntmr_q - 8'd1;
                if (ntmr_q == 8'd1) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                reading_d = (cnt_q > CNT_W'(99)) ? 7'd99 : 7'(cnt_q);
                cnt_d     = '0;
                chg_d     = '0;
                state_d   = ST_CHARGE;
            end
            default: state_d = ST_CHARGE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        tmr_d   = tmr_q + 1'b1;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (tmr_q == TW'(DIGIT_HOLD - 1)) begin
            tmr_d = '0;
            case (phase_q)
                PH_BLANK: begin
                    phase_d = PH_TENS;
                    tens_d  = 4'(reading_q / 7'd10);
                    ones_d  = 4'(reading_q % 7'd10);
                end
                PH_TENS: phase_d = PH_ONES;
                default: phase_d = PH_BLANK;
            endcase
        end
        case (phase_q)
            PH_TENS: seg_d = (tens_q == 4'd0) ? 7'h00 : seg7(tens_q);
            PH_ONES: seg_d = seg7(ones_q);
            default: seg_d = 7'h00;
        endcase
        pwm_d = (state_q != ST_LATCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CHARGE;
            chg_q     <= '0;
            cnt_q     <= '0;
            ntmr_q    <= '0;
            reading_q <= '0;
            phase_q   <= PH_BLANK;
            tmr_q     <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            seg_q     <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            chg_q     <= chg_d;
            cnt_q     <= cnt_d;
            ntmr_q    <= ntmr_d;
            reading_q <= reading_d;
            phase_q   <= phase_d;
            tmr_q     <= tmr_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            seg_q     <= seg_d;
            pwm_q     <= pwm_d;
        end
    end

    assign io_out = {pwm_q, seg_q};

endmodule

// File: tb/tb_tt03_temperature_sensor.sv
// Bench for tt03_temperature_sensor: directed vector table, hand sequences and
// randomized configuration changes checked against a cycle-level reference model.
module tb_tt03_temperature_sensor;

    localparam int CHARGE_SLOW = 4;
    localparam int DIGIT_HOLD  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       quick = 1'b0;
    logic [4:0] cfg   = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {cfg, quick, rst_n, clk};

    tt03_temperature_sensor #(
        .CNT_W      (8),
        .CHARGE_SLOW(CHARGE_SLOW),
        .DIGIT_HOLD (DIGIT_HOLD)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: t = cycles into the current measurement, which lasts
    // clen (charge) + D (discharge) + 1 (latch) cycles; dt = cycles since reset.
    int t = 0, clen = CHARGE_SLOW, D = 4, reading = 0, dt = 0, snap_r = 0, ph = 0;
    logic [6:0] s;
    logic [7:0] exp_out = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; clen = CHARGE_SLOW; D = 4; reading = 0; dt = 0; snap_r = 0;
            exp_out = 8'h00;
        end else begin
            ph = (dt / DIGIT_HOLD) % 3;
            s  = 7'h00;
            if (ph == 1 && snap_r / 10 != 0) s = SEG[snap_r / 10];
            else if (ph == 2)                s = SEG[snap_r % 10];
            if (dt % (3 * DIGIT_HOLD) == DIGIT_HOLD - 1) snap_r = reading;
            dt++;
            if (t == 0) clen = quick ? 1 : CHARGE_SLOW;
            if (t == clen - 1) D = 4 * (int'(cfg) + 1);
            exp_out = {t != clen + D, s};
            if (t == clen + D) begin
                reading = (D > 99) ? 99 : D;
                t = 0;
            end else begin
                t++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (io_out !== exp_out) begin
                errors++;
                $display("FAIL model @%0t: io_out=%h expected=%h", $time, io_out, exp_out);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_out", int'(io_out), 0);
        repeat (3) @(negedge clk);
        check("reset_hold_out", int'(io_out), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (io_out[7] === lvl && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       q;
        int         c;
        int         hi;
        logic [6:0] tens;
        logic [6:0] ones;
    } vec_t;

    vec_t vecs [6];
    int   h1, lo, h2;

    initial begin
        vecs[0] = '{1'b0, 3,  20,  7'h06, 7'h7D};
        vecs[1] = '{1'b1, 3,  17,  7'h06, 7'h7D};
        vecs[2] = '{1'b1, 0,  5,   7'h00, 7'h66};
        vecs[3] = '{1'b1, 31, 129, 7'h6F, 7'h6F};
        vecs[4] = '{1'b0, 31, 132, 7'h6F, 7'h6F};
        vecs[5] = '{1'b0, 9,  44,  7'h66, 7'h3F};

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out", int'(io_out), 0);

        // Release: pwm up at once, display blank for the hold, then a lone 0.
        quick = 1'b0; cfg = 5'd3;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("pwm_first_cycle", int'(io_out[7]), 1);
        while (dt <= DIGIT_HOLD) begin
            check("blank_after_reset", int'(io_out[6:0]), 0);
            @(negedge clk);
        end
        while (dt != 2 * DIGIT_HOLD + 1) @(negedge clk);
        check("ones_zero_before_latch", int'(io_out[6:0]), 'h3F);

        foreach (vecs[i]) begin
            quick = vecs[i].q; cfg = 5'(vecs[i].c);
            reset_dut();
            run_len(1'b1, h1);
            check($sformatf("v%0d_first_high", i), h1, vecs[i].hi);
            run_len(1'b0, lo);
            check($sformatf("v%0d_low", i), lo, 1);
            run_len(1'b1, h2);
            check($sformatf("v%0d_period_high", i), h2, vecs[i].hi);
            repeat (3 * DIGIT_HOLD) @(negedge clk);
            while (dt % (3 * DIGIT_HOLD) != DIGIT_HOLD + 5) @(negedge clk);
            check($sformatf("v%0d_tens", i), int'(io_out[6:0]), int'(vecs[i].tens));
            repeat (DIGIT_HOLD) @(negedge clk);
            check($sformatf("v%0d_ones", i), int'(io_out[6:0]), int'(vecs[i].ones));
        end

        // cfg change mid-discharge only affects the next measurement.
        quick = 1'b0; cfg = 5'd3;
        reset_dut();
        h1 = 0;
        while (io_out[7] === 1'b1 && h1 < 400) begin
            if (h1 == 10) cfg = 5'd0;
            h1++;
            @(negedge clk);
        end
        check("cfgchg_first_high", h1, 20);
        run_len(1'b0, lo);
        check("cfgchg_low", lo, 1);
        run_len(1'b1, h2);
        check("cfgchg_second_high", h2, 8);

        // Reset pulse mid-discharge, then a full first period again.
        cfg = 5'd3;
        reset_dut();
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_discharge_reset", int'(io_out), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_len(1'b1, h1);
        check("restart_first_high", h1, 20);

        // Randomized configuration changes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                cfg   = 5'($urandom_range(0, 31));
                quick = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_reset", int'(io_out), 0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
